sel_debounce: RTL and testbench

- Upstream front end for the 2-to-4 one-hot decoder.
- Takes raw board switch inputs (2-bit select plus enable), synchronises them to clk, and debounces them.
- Presents stable x[1:0]/en to the decoder, plus a 1-cycle update strobe and a busy flag for an LED/status stage.
- The 3 inputs are debounced as one vector, so x and en never change on different cycles.

---
 rtl/sel_debounce.sv | 75 +++++++
 tb/tb_sel_debounce.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sel_debounce.sv
// Switch front end for the 2-to-4 decoder: two-flop synchroniser followed by a
// single-vector debouncer, so {en,x} always change together on one edge.
module sel_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw_sel,
    input  logic       sw_en,
    output logic [1:0] x,
    output logic       en,
    output logic       upd,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       s1_q;
    logic [2:0]       s2_q;
    logic [2:0]       cand_q;
    logic [2:0]       cand_d;
    logic [2:0]       out_q;
    logic [2:0]       out_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             upd_q;
    logic             upd_d;

    // Next-state selection; a fresh synchronised value always restarts the window,
    // even on the edge that would otherwise have committed.
    always_comb begin
        cand_d = cand_q;
        out_d  = out_q;
        cnt_d  = cnt_q;
        upd_d  = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = {CNT_W{1'b0}};
        end else if (cand_q == out_q) begin
            cnt_d  = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            out_d  = cand_q;
            cnt_d  = {CNT_W{1'b0}};
            upd_d  = 1'b1;
        end else begin
            cnt_d  = cnt_q + CNT_ONE;
        end
    end

    // State registers; reset discards any pending candidate and the synchroniser contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 3'b000;
            s2_q   <= 3'b000;
            cand_q <= 3'b000;
            out_q  <= 3'b000;
            cnt_q  <= {CNT_W{1'b0}};
            upd_q  <= 1'b0;
        end else begin
            s1_q   <= {sw_en, sw_sel};
            s2_q   <= s1_q;
            cand_q <= cand_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            upd_q  <= upd_d;
        end
    end

    assign {en, x} = out_q;
    assign upd     = upd_q;
    assign busy    = (cand_q != out_q);

endmodule

// File: tb/tb_sel_debounce.sv
// Scoreboard bench for sel_debounce: expected {en,x,upd,busy} per edge are queued
// from the documented latency rules, then popped and compared after each edge.
module tb_sel_debounce;

    logic       clk;
    logic       rst4;
    logic       rst1;
    logic [2:0] raw4;
    logic [2:0] raw1;
    logic [1:0] x4;
    logic [1:0] x1;
    logic       en4, upd4, busy4;
    logic       en1, upd1, busy1;
    logic [4:0] obs4;
    logic [4:0] obs1;
    logic [4:0] sbq[$];
    logic [4:0] e;
    int         vectors;
    int         miscompares;

    sel_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(5)) dut4 (
        .clk(clk), .rst(rst4), .sw_sel(raw4[1:0]), .sw_en(raw4[2]),
        .x(x4), .en(en4), .upd(upd4), .busy(busy4)
    );

    sel_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst1), .sw_sel(raw1[1:0]), .sw_en(raw1[2]),
        .x(x1), .en(en1), .upd(upd1), .busy(busy1)
    );

    assign obs4 = {en4, x4, upd4, busy4};
    assign obs1 = {en1, x1, upd1, busy1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Steady change first sampled at edge k=0: busy from k=2, commit and upd at k=d+2.
    function automatic void push_change(input logic [2:0] old_v, input logic [2:0] new_v,
                                        input int d, input int n);
        for (int k = 0; k < n; k++)
            sbq.push_back({(k >= d + 2) ? new_v : old_v, (k == d + 2), (k >= 2 && k < d + 2)});
    endfunction

    task automatic test_reset();
        rst4 = 1'b1;
        rst1 = 1'b1;
        raw4 = 3'b111;
        raw1 = 3'b000;
        for (int k = 0; k < 2; k++) sbq.push_back(5'b00000);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL reset_hold edge %0d: got %b want %b", k, obs4, e);
            end
        end
        rst4 = 1'b0;
        push_change(3'b000, 3'b111, 4, 9);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL reset_release edge %0d: got %b want %b", k, obs4, e);
            end
        end
    endtask

    task automatic test_clean(input logic [2:0] old_v, input logic [2:0] new_v);
        raw4 = new_v;
        push_change(old_v, new_v, 4, 8);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL clean %b->%b edge %0d: got %b want %b", old_v, new_v, k, obs4, e);
            end
        end
    endtask

    // Glitch held for w sampled edges (w <= 4) must never reach the output.
    task automatic test_glitch(input logic [2:0] base, input logic [2:0] glitch, input int w);
        raw4 = glitch;
        for (int k = 0; k < w + 5; k++)
            sbq.push_back({base, 1'b0, (k >= 2 && k <= w + 1)});
        for (int k = 0; k < w + 5; k++) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL glitch w=%0d edge %0d: got %b want %b", w, k, obs4, e);
            end
            if (k + 1 == w) raw4 = base;
        end
    endtask

    task automatic test_bounce();
        logic cand_en;
        logic out_en;
        test_clean(3'b100, 3'b000);
        for (int k = 0; k < 18; k++) begin
            cand_en = (k < 2) ? 1'b0 : ((k - 2 >= 8) ? 1'b1 : (((k - 2) / 2) % 2 == 0));
            out_en  = (k >= 14);
            sbq.push_back({out_en, 2'b00, (k == 14), (cand_en != out_en)});
        end
        raw4 = 3'b100;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL bounce edge %0d: got %b want %b", k, obs4, e);
            end
            raw4 = {((k + 1 >= 8) ? 1'b1 : (((k + 1) / 2) % 2 == 0)), 2'b00};
        end
    endtask

    task automatic test_reset_midcount();
        raw4 = 3'b111;
        push_change(3'b100, 3'b111, 4, 4);
        sbq.push_back(5'b00000);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) rst4 = 1'b1;
            @(posedge clk); #1;
            e = sbq.pop_front();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL midcount_pre edge %0d: got %b want %b", k, obs4, e);
            end
        end
        rst4 = 1'b0;
        push_change(3'b000, 3'b111, 4, 9);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL midcount_post edge %0d: got %b want %b", k, obs4, e);
            end
        end
    endtask

    task automatic test_d1_multibit();
        sbq.push_back(5'b00000);
        @(posedge clk); #1;
        e = sbq.pop_front();
        vectors++;
        if (obs1 !== e) begin
            miscompares++;
            $display("FAIL d1_reset: got %b want %b", obs1, e);
        end
        raw1 = 3'b111;
        rst1 = 1'b0;
        push_change(3'b000, 3'b111, 1, 6);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            vectors++;
            if (obs1 !== e) begin
                miscompares++;
                $display("FAIL d1_multibit edge %0d: got %b want %b", k, obs1, e);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_clean(3'b111, 3'b100);
        test_clean(3'b100, 3'b110);
        test_clean(3'b110, 3'b100);
        test_glitch(3'b100, 3'b101, 3);
        test_glitch(3'b100, 3'b101, 4);
        test_bounce();
        test_reset_midcount();
        test_d1_multibit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
